age_issue_queue: RTL and testbench

// - Parametrised out-of-order issue queue: the successor to the fixed 4-entry ALU IQ.
// - Accepts up to DISPATCH_CNT instructions per cycle from dispatch.
// - Holds IQ_SIZE entries and captures operands from CDB_COUNT result buses.
// - Issues the oldest fully-ready entry through a registered valid/ready port to its execute unit.
// - Sits between dispatch/rename and one execute pipe (ALU, MUL or LSU-address); one instance per pipe.

---
 rtl/age_issue_queue_pkg.sv | 17 +
 rtl/age_issue_queue_if.sv | 43 ++++
 rtl/age_issue_queue_slot.sv | 88 ++++++++
 rtl/age_issue_queue.sv | 159 +++++++++++++++
 tb/tb_age_issue_queue.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/age_issue_queue_pkg.sv
// Shared types for the age-ordered issue queue: machine word, ROB tag and
// the per-operand record each slot keeps while it waits on a producer.
package age_issue_queue_pkg;

    localparam int WORD_W   = 32;
    localparam int ROB_ID_W = 6;

    typedef logic [WORD_W-1:0]   word_t;
    typedef logic [ROB_ID_W-1:0] rob_id_t;

    typedef struct packed {
        word_t   data;
        rob_id_t tag;
        logic    rdy;
    } iq_operand_t;

endpackage

// File: rtl/age_issue_queue_if.sv
// Dispatch, CDB snoop and issue bundle between rename/dispatch, the issue
// queue (slave) and its execute pipe; the bench drives the master side.
interface age_issue_queue_if #(
    parameter int IQ_SIZE      = 8,
    parameter int DISPATCH_CNT = 2,
    parameter int REG_COUNT    = 2,
    parameter int CDB_COUNT    = 2,
    parameter int PAYLOAD_W    = 64
);
    import age_issue_queue_pkg::*;

    localparam int CNT_W = $clog2(IQ_SIZE + 1);

    logic    [DISPATCH_CNT-1:0]                 dis_valid_i;
    logic    [DISPATCH_CNT-1:0][PAYLOAD_W-1:0]  dis_payload_i;
    word_t   [DISPATCH_CNT-1:0][REG_COUNT-1:0]  dis_data_i;
    rob_id_t [DISPATCH_CNT-1:0][REG_COUNT-1:0]  dis_tag_i;
    logic    [DISPATCH_CNT-1:0][REG_COUNT-1:0]  dis_rdy_i;
    logic                                       dis_ready_o;
    logic    [CNT_W-1:0]                        free_cnt_o;

    logic    [CDB_COUNT-1:0]                    cdb_valid_i;
    rob_id_t [CDB_COUNT-1:0]                    cdb_tag_i;
    word_t   [CDB_COUNT-1:0]                    cdb_data_i;

    logic                                       iss_valid_o;
    logic                                       iss_ready_i;
    logic    [PAYLOAD_W-1:0]                    iss_payload_o;
    word_t   [REG_COUNT-1:0]                    iss_data_o;

    modport slave (
        input  dis_valid_i, dis_payload_i, dis_data_i, dis_tag_i, dis_rdy_i,
        input  cdb_valid_i, cdb_tag_i, cdb_data_i, iss_ready_i,
        output dis_ready_o, free_cnt_o, iss_valid_o, iss_payload_o, iss_data_o
    );

    modport master (
        output dis_valid_i, dis_payload_i, dis_data_i, dis_tag_i, dis_rdy_i,
        output cdb_valid_i, cdb_tag_i, cdb_data_i, iss_ready_i,
        input  dis_ready_o, free_cnt_o, iss_valid_o, iss_payload_o, iss_data_o
    );

endinterface

// File: rtl/age_issue_queue_slot.sv
// One issue-queue entry: holds payload and operands, snoops the CDBs for
// operands still waiting, and reports when every operand is ready.
module age_issue_queue_slot
    import age_issue_queue_pkg::*;
#(
    parameter int REG_COUNT = 2,
    parameter int CDB_COUNT = 2,
    parameter int PAYLOAD_W = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic                              alloc_i,
    input  logic        [PAYLOAD_W-1:0]       alloc_payload_i,
    input  iq_operand_t [REG_COUNT-1:0]       alloc_ops_i,
    input  logic                              free_i,
    input  logic        [CDB_COUNT-1:0]       cdb_valid_i,
    input  rob_id_t     [CDB_COUNT-1:0]       cdb_tag_i,
    input  word_t       [CDB_COUNT-1:0]       cdb_data_i,
    output logic                              valid_o,
    output logic                              ready_o,
    output logic        [PAYLOAD_W-1:0]       payload_o,
    output word_t       [REG_COUNT-1:0]       data_o
);

    logic                          valid_q, valid_d;
    logic        [PAYLOAD_W-1:0]   payload_q, payload_d;
    iq_operand_t [REG_COUNT-1:0]   ops_q, ops_d;
    iq_operand_t [REG_COUNT-1:0]   src, snooped;

    // Incoming operands go through the same snoop, giving dispatch-cycle bypass.
    // Scanning CDBs high to low lets the lowest matching bus win.
    always_comb begin
        src     = alloc_i ? alloc_ops_i : ops_q;
        snooped = src;
        for (int r = 0; r < REG_COUNT; r++) begin
            for (int c = CDB_COUNT - 1; c >= 0; c--) begin
                if (!src[r].rdy && cdb_valid_i[c] && (cdb_tag_i[c] == src[r].tag)) begin
                    snooped[r].data = cdb_data_i[c];
                    snooped[r].rdy  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        ops_d     = ops_q;
        if (alloc_i) begin
            valid_d   = 1'b1;
            payload_d = alloc_payload_i;
            ops_d     = snooped;
        end else if (free_i) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            ops_d = snooped;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ops_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ops_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            ops_q     <= ops_d;
        end
    end

    always_comb begin
        ready_o = 1'b1;
        for (int r = 0; r < REG_COUNT; r++) begin
            ready_o = ready_o & ops_q[r].rdy;
            data_o[r] = snooped[r].data;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue: allocates dispatched instructions into free
// slots, tracks relative age in a matrix and issues the oldest ready entry.
module age_issue_queue
    import age_issue_queue_pkg::*;
#(
    parameter int IQ_SIZE      = 8,
    parameter int DISPATCH_CNT = 2,
    parameter int REG_COUNT    = 2,
    parameter int CDB_COUNT    = 2,
    parameter int PAYLOAD_W    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    age_issue_queue_if.slave  io
);

    localparam int CNT_W = $clog2(IQ_SIZE + 1);

    logic        [IQ_SIZE-1:0]                  slot_valid, slot_ready, alloc_en, taken;
    logic        [IQ_SIZE-1:0]                  cand, oldest, grant;
    logic        [IQ_SIZE-1:0][PAYLOAD_W-1:0]   slot_payload, alloc_payload;
    word_t       [IQ_SIZE-1:0][REG_COUNT-1:0]   slot_data;
    iq_operand_t [IQ_SIZE-1:0][REG_COUNT-1:0]   alloc_ops;
    logic        [IQ_SIZE-1:0][IQ_SIZE-1:0]     age_q, age_d;
    logic        [CNT_W-1:0]                    free_q, free_d, alloc_num;
    logic                                       dis_ready_q, dis_ready_d, placed, load, issued;
    logic                                       iss_valid_q;
    logic        [PAYLOAD_W-1:0]                iss_payload_q, out_payload;
    word_t       [REG_COUNT-1:0]                iss_data_q, out_data;

    // Each accepted port takes the lowest slot still free at the start of the cycle,
    // so port order equals ascending slot order among this cycle's allocations.
    always_comb begin
        taken         = slot_valid;
        alloc_en      = '0;
        alloc_payload = '0;
        alloc_ops     = '0;
        alloc_num     = '0;
        placed        = 1'b0;
        for (int p = 0; p < DISPATCH_CNT; p++) begin
            if (dis_ready_q && io.dis_valid_i[p]) begin
                placed    = 1'b0;
                alloc_num = alloc_num + CNT_W'(1);
                for (int i = 0; i < IQ_SIZE; i++) begin
                    if (!placed && !taken[i]) begin
                        placed           = 1'b1;
                        taken[i]         = 1'b1;
                        alloc_en[i]      = 1'b1;
                        alloc_payload[i] = io.dis_payload_i[p];
                        for (int r = 0; r < REG_COUNT; r++) begin
                            alloc_ops[i][r] = '{data: io.dis_data_i[p][r],
                                                tag:  io.dis_tag_i[p][r],
                                                rdy:  io.dis_rdy_i[p][r]};
                        end
                    end
                end
            end
        end
    end

    // A new entry becomes younger than everything; later slots in the same cycle override.
    always_comb begin
        age_d = age_q;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (alloc_en[i]) begin
                for (int j = 0; j < IQ_SIZE; j++) begin
                    if (j != i) begin
                        age_d[i][j] = 1'b0;
                        age_d[j][i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        cand   = slot_valid & slot_ready;
        oldest = cand;
        for (int i = 0; i < IQ_SIZE; i++) begin
            for (int j = 0; j < IQ_SIZE; j++) begin
                if (cand[j] && age_q[j][i]) oldest[i] = 1'b0;
            end
        end
        load        = !iss_valid_q || io.iss_ready_i;
        grant       = load ? oldest : '0;
        issued      = |grant;
        out_payload = '0;
        out_data    = '0;
        for (int i = 0; i < IQ_SIZE; i++) begin
            if (grant[i]) begin
                out_payload = out_payload | slot_payload[i];
                out_data    = out_data | slot_data[i];
            end
        end
        free_d      = free_q - alloc_num + CNT_W'(issued);
        dis_ready_d = (free_d >= CNT_W'(DISPATCH_CNT));
    end

    for (genvar i = 0; i < IQ_SIZE; i++) begin : gen_slot
        age_issue_queue_slot #(
            .REG_COUNT (REG_COUNT),
            .CDB_COUNT (CDB_COUNT),
            .PAYLOAD_W (PAYLOAD_W)
        ) u_slot (
            .clk             (clk),
            .rst_n           (rst_n),
            .flush           (flush),
            .alloc_i         (alloc_en[i]),
            .alloc_payload_i (alloc_payload[i]),
            .alloc_ops_i     (alloc_ops[i]),
            .free_i          (grant[i]),
            .cdb_valid_i     (io.cdb_valid_i),
            .cdb_tag_i       (io.cdb_tag_i),
            .cdb_data_i      (io.cdb_data_i),
            .valid_o         (slot_valid[i]),
            .ready_o         (slot_ready[i]),
            .payload_o       (slot_payload[i]),
            .data_o          (slot_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_q         <= '0;
            free_q        <= CNT_W'(IQ_SIZE);
            dis_ready_q   <= 1'b1;
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_data_q    <= '0;
        end else if (flush) begin
            age_q         <= '0;
            free_q        <= CNT_W'(IQ_SIZE);
            dis_ready_q   <= 1'b1;
            iss_valid_q   <= 1'b0;
            iss_payload_q <= '0;
            iss_data_q    <= '0;
        end else begin
            age_q       <= age_d;
            free_q      <= free_d;
            dis_ready_q <= dis_ready_d;
            if (load) begin
                iss_valid_q   <= issued;
                iss_payload_q <= out_payload;
                iss_data_q    <= out_data;
            end
        end
    end

    assign io.dis_ready_o   = dis_ready_q;
    assign io.free_cnt_o    = free_q;
    assign io.iss_valid_o   = iss_valid_q;
    assign io.iss_payload_o = iss_payload_q;
    assign io.iss_data_o    = iss_data_q;

    dispatchWhileFull: assert property (@(posedge clk) disable iff (!rst_n || flush)
        !(|io.dis_valid_i && !dis_ready_q));

endmodule

// File: tb/tb_age_issue_queue.sv
// Randomized and directed bench for age_issue_queue against an age-ordered
// list model of the queue contents and the issue register.
module tb_age_issue_queue;
    import age_issue_queue_pkg::*;

    localparam int IQ_SIZE = 8;
    localparam int DCNT    = 2;
    localparam int RCNT    = 2;
    localparam int CDBN    = 2;
    localparam int PW      = 64;

    typedef struct packed {
        logic    [PW-1:0]   payload;
        word_t   [RCNT-1:0] data;
        rob_id_t [RCNT-1:0] tag;
        logic    [RCNT-1:0] rdy;
    } mEntry_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    mEntry_t                modelQ[$];
    logic                   mIssValid;
    logic     [PW-1:0]      mIssPayload;
    word_t    [RCNT-1:0]    mIssData;
    logic                   mDisReady;

    age_issue_queue_if #(.IQ_SIZE(IQ_SIZE), .DISPATCH_CNT(DCNT), .REG_COUNT(RCNT),
                         .CDB_COUNT(CDBN), .PAYLOAD_W(PW)) io ();

    age_issue_queue #(.IQ_SIZE(IQ_SIZE), .DISPATCH_CNT(DCNT), .REG_COUNT(RCNT),
                      .CDB_COUNT(CDBN), .PAYLOAD_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [32:0] snoopOp(input rob_id_t tag, input logic rdy, input word_t data);
        logic [32:0] res;
        res = {rdy, data};
        for (int c = 0; c < CDBN; c++) begin
            if (!res[32] && io.cdb_valid_i[c] && io.cdb_tag_i[c] == tag) res = {1'b1, io.cdb_data_i[c]};
        end
        return res;
    endfunction

    task automatic modelReset();
        modelQ.delete();
        mIssValid   = 1'b0;
        mIssPayload = '0;
        mIssData    = '0;
        mDisReady   = 1'b1;
    endtask

    // One clock edge of the queue: issue oldest ready, snoop, append new dispatches.
    task automatic modelStep();
        mEntry_t     e;
        int          pick;
        logic [32:0] s;
        if (flush) begin
            modelReset();
            return;
        end
        if (!mIssValid || io.iss_ready_i) begin
            pick = -1;
            for (int k = 0; k < modelQ.size(); k++) if (pick < 0 && &modelQ[k].rdy) pick = k;
            if (pick >= 0) begin
                mIssValid   = 1'b1;
                mIssPayload = modelQ[pick].payload;
                mIssData    = modelQ[pick].data;
                modelQ.delete(pick);
            end else begin
                mIssValid = 1'b0;
            end
        end
        for (int k = 0; k < modelQ.size(); k++) begin
            e = modelQ[k];
            for (int r = 0; r < RCNT; r++) begin
                s = snoopOp(e.tag[r], e.rdy[r], e.data[r]);
                e.rdy[r]  = s[32];
                e.data[r] = s[31:0];
            end
            modelQ[k] = e;
        end
        if (mDisReady) begin
            for (int p = 0; p < DCNT; p++) begin
                if (io.dis_valid_i[p]) begin
                    e.payload = io.dis_payload_i[p];
                    for (int r = 0; r < RCNT; r++) begin
                        s = snoopOp(io.dis_tag_i[p][r], io.dis_rdy_i[p][r], io.dis_data_i[p][r]);
                        e.tag[r]  = io.dis_tag_i[p][r];
                        e.rdy[r]  = s[32];
                        e.data[r] = s[31:0];
                    end
                    modelQ.push_back(e);
                end
            end
        end
        mDisReady = (IQ_SIZE - modelQ.size()) >= DCNT;
    endtask

    task automatic checkAll();
        checkOutput("iss_valid", io.iss_valid_o, mIssValid);
        if (mIssValid) begin
            checkOutput("iss_payload", io.iss_payload_o, mIssPayload);
            checkOutput("iss_data", io.iss_data_o, mIssData);
        end
        checkOutput("free_cnt", io.free_cnt_o, IQ_SIZE - modelQ.size());
        checkOutput("dis_ready", io.dis_ready_o, mDisReady);
    endtask

    task automatic stepCycle();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic clearInputs();
        flush            = 1'b0;
        io.dis_valid_i   = '0;
        io.dis_payload_i = '0;
        io.dis_data_i    = '0;
        io.dis_tag_i     = '0;
        io.dis_rdy_i     = '0;
        io.cdb_valid_i   = '0;
        io.cdb_tag_i     = '0;
        io.cdb_data_i    = '0;
        io.iss_ready_i   = 1'b1;
    endtask

    task automatic setDispatch(input int p, input logic [PW-1:0] payload, input rob_id_t t0,
                               input logic r0, input word_t d0);
        io.dis_valid_i[p]    = 1'b1;
        io.dis_payload_i[p]  = payload;
        io.dis_tag_i[p][0]   = t0;
        io.dis_rdy_i[p][0]   = r0;
        io.dis_data_i[p][0]  = d0;
        io.dis_tag_i[p][1]   = '0;
        io.dis_rdy_i[p][1]   = 1'b1;
        io.dis_data_i[p][1]  = 32'h55 + p;
    endtask

    task automatic setCdb(input int c, input rob_id_t tag, input word_t data);
        io.cdb_valid_i[c] = 1'b1;
        io.cdb_tag_i[c]   = tag;
        io.cdb_data_i[c]  = data;
    endtask

    task automatic applyStimulus(input bit allowFlush);
        flush = allowFlush && ($urandom_range(0, 63) == 0);
        for (int p = 0; p < DCNT; p++) begin
            io.dis_valid_i[p]   = mDisReady && ($urandom_range(0, 2) != 0);
            io.dis_payload_i[p] = {$urandom, $urandom};
            for (int r = 0; r < RCNT; r++) begin
                io.dis_tag_i[p][r]  = rob_id_t'($urandom_range(0, 7));
                io.dis_rdy_i[p][r]  = $urandom_range(0, 1) == 1;
                io.dis_data_i[p][r] = $urandom;
            end
        end
        for (int c = 0; c < CDBN; c++) begin
            io.cdb_valid_i[c] = $urandom_range(0, 1) == 1;
            io.cdb_tag_i[c]   = rob_id_t'($urandom_range(0, 7));
            io.cdb_data_i[c]  = $urandom;
        end
        io.iss_ready_i = $urandom_range(0, 3) != 0;
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkAll();

        $display("[TB] two ready dispatches, issue stalled for three cycles");
        setDispatch(0, 64'h100, 6'd0, 1'b1, 32'h11);
        setDispatch(1, 64'h101, 6'd0, 1'b1, 32'h22);
        io.iss_ready_i = 1'b0;
        stepCycle();
        clearInputs();
        io.iss_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("stall_payload", io.iss_payload_o, 64'h100);
        end
        io.iss_ready_i = 1'b1;
        stepCycle();
        checkOutput("second_payload", io.iss_payload_o, 64'h101);
        stepCycle();
        stepCycle();

        $display("[TB] younger entry woken first");
        setDispatch(0, 64'hA5, 6'd5, 1'b0, 32'h0);
        stepCycle();
        clearInputs();
        setDispatch(0, 64'hA9, 6'd9, 1'b0, 32'h0);
        stepCycle();
        clearInputs();
        setCdb(1, 6'd9, 32'h1234);
        stepCycle();
        clearInputs();
        stepCycle();
        checkOutput("tag9_data", io.iss_data_o[0], 32'h1234);
        setCdb(0, 6'd5, 32'h5555);
        stepCycle();
        clearInputs();
        stepCycle();
        checkOutput("tag5_payload", io.iss_payload_o, 64'hA5);
        stepCycle();

        $display("[TB] dispatch-cycle bypass");
        setDispatch(0, 64'hB3, 6'd3, 1'b0, 32'h0);
        setCdb(0, 6'd3, 32'hABCD);
        stepCycle();
        clearInputs();
        stepCycle();
        checkOutput("bypass_data", io.iss_data_o[0], 32'hABCD);
        stepCycle();
        stepCycle();

        $display("[TB] fill queue, then flush");
        for (int k = 0; k < IQ_SIZE / DCNT; k++) begin
            clearInputs();
            io.iss_ready_i = 1'b0;
            setDispatch(0, 64'hF00 + 2 * k, 6'd7, 1'b0, 32'h0);
            setDispatch(1, 64'hF01 + 2 * k, 6'd7, 1'b0, 32'h0);
            stepCycle();
        end
        checkOutput("full_free", io.free_cnt_o, 0);
        checkOutput("full_ready", io.dis_ready_o, 1'b0);
        clearInputs();
        io.iss_ready_i = 1'b0;
        setCdb(0, 6'd7, 32'h7777);
        stepCycle();
        clearInputs();
        io.iss_ready_i = 1'b0;
        stepCycle();
        checkOutput("one_free", io.free_cnt_o, 1);
        checkOutput("one_free_ready", io.dis_ready_o, 1'b0);
        checkOutput("one_free_payload", io.iss_payload_o, 64'hF00);
        flush = 1'b1;
        stepCycle();
        checkOutput("flush_valid", io.iss_valid_o, 1'b0);
        checkOutput("flush_free", io.free_cnt_o, IQ_SIZE);
        clearInputs();

        $display("[TB] randomized traffic");
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(1'b1);
            stepCycle();
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0);
            io.iss_ready_i = 1'b0;
            stepCycle();
        end

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_valid", io.iss_valid_o, 1'b0);
        checkOutput("async_free", io.free_cnt_o, IQ_SIZE);
        checkOutput("async_ready", io.dis_ready_o, 1'b1);
        modelReset();
        clearInputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checkAll();
        for (int k = 0; k < 200; k++) begin
            applyStimulus(1'b1);
            stepCycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
